// File: rtl/fpdu_pkg.sv
// Shared types and helpers for the fixed-point divider.
// Sign/magnitude extraction is common to the FPMU family.
package fpdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] fp_mag(
        input logic [31:0] x,
        input logic        neg
    );
        return neg ? 32'(-x) : x;
    endfunction

endpackage

// File: rtl/fpdu_step.sv
// One restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it fits.
module fpdu_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_diff;

    assign w_sh   = {i_rem, i_bit};
    assign w_diff = w_sh - {1'b0, i_div};
    assign o_q    = (w_sh >= {1'b0, i_div});
    assign o_rem  = o_q ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];

endmodule

// File: rtl/fpdu_seq.sv
// Sequential restoring fixed-point divider, one quotient bit per clock,
// with saturation and divide-by-zero reporting.
module fpdu_seq
    import fpdu_pkg::*;
#(
    parameter int SIGN         = 1,
    parameter int WIDTH        = 8,
    parameter int FP_POSITIONS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int N  = WIDTH + FP_POSITIONS;
    localparam int CW = $clog2(N);

    localparam logic [N-1:0] LIM_P = N'((1 << (WIDTH - 1)) - 1);
    localparam logic [N-1:0] LIM_N = N'(1 << (WIDTH - 1));
    localparam logic [N-1:0] LIM_U = N'((1 << WIDTH) - 1);

    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_d;
    logic [N-1:0]     r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_bmag;
    logic             r_neg;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH-1:0] w_rem;
    logic             w_qbit;
    logic [N-1:0]     w_q;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    assign w_a_neg = (SIGN != 0) && a[WIDTH-1];
    assign w_b_neg = (SIGN != 0) && b[WIDTH-1];
    assign w_amag  = WIDTH'(fp_mag(32'(a), w_a_neg));
    assign w_bmag  = WIDTH'(fp_mag(32'(b), w_b_neg));

    fpdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem(r_rem),
        .i_bit(r_d[N-1]),
        .i_div(r_bmag),
        .o_rem(w_rem),
        .o_q  (w_qbit)
    );

    assign w_q = {r_q[N-2:0], w_qbit};

    // A zero quotient negates to zero, so -0 never appears.
    always_comb begin
        w_res = w_q[WIDTH-1:0];
        w_ovf = 1'b0;
        if (SIGN == 0) begin
            if (w_q > LIM_U) begin
                w_res = '1;
                w_ovf = 1'b1;
            end
        end else if (r_neg) begin
            if (w_q > LIM_N) begin
                w_res = MINN;
                w_ovf = 1'b1;
            end else begin
                w_res = -w_q[WIDTH-1:0];
            end
        end else if (w_q > LIM_P) begin
            w_res = MAXP;
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_d         <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_bmag      <= '0;
            r_neg       <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (b == '0) begin
                            r_state     <= DONE;
                            out_valid   <= 1'b1;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b1;
                            if (SIGN == 0) begin
                                out_data <= '1;
                            end else begin
                                out_data <= a[WIDTH-1] ? MINN : MAXP;
                            end
                        end else begin
                            r_state <= DIV;
                            r_cnt   <= '0;
                            r_d     <= N'(w_amag) << FP_POSITIONS;
                            r_q     <= '0;
                            r_rem   <= '0;
                            r_bmag  <= w_bmag;
                            r_neg   <= w_a_neg ^ w_b_neg;
                        end
                    end
                end
                DIV: begin
                    r_d   <= {r_d[N-2:0], 1'b0};
                    r_q   <= w_q;
                    r_rem <= w_rem;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state     <= DONE;
                        out_valid   <= 1'b1;
                        out_data    <= w_res;
                        overflow    <= w_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
